// File: rtl/msg_disasm.sv
// Packet-to-word serialiser: takes one WORD_SIZE*WORDS_PER_PACKET packet and
// emits it as WORDS_PER_PACKET words, with optional idle cycles between words.
module msg_disasm #(
    parameter int unsigned WORD_SIZE        = 8,
    parameter int unsigned WORDS_PER_PACKET = 4,
    parameter int unsigned MSW_FIRST        = 1,
    parameter int unsigned GAP_CYCLES       = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_in,
    input  logic                                  data_in_valid,
    output logic                                  data_in_ready,
    output logic [WORD_SIZE-1:0]                  data_out,
    output logic                                  data_out_valid,
    input  logic                                  data_out_ready,
    output logic                                  busy
);

    localparam int unsigned PW = WORD_SIZE * WORDS_PER_PACKET;
    localparam int unsigned CW = $clog2(WORDS_PER_PACKET);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_PACKET - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   wcnt_q,  wcnt_d;
    logic [GW-1:0]   gcnt_q,  gcnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            IDLE: begin
                if (data_in_valid && data_in_ready) begin
                    shreg_d = data_in;
                    wcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (data_out_ready) begin
                    if (wcnt_q == LAST_WORD) begin
                        state_d = IDLE;
                    end else begin
                        // Shift the next word into the emit position.
                        if (MSW_FIRST != 0) shreg_d = shreg_q << WORD_SIZE;
                        else                shreg_d = shreg_q >> WORD_SIZE;
                        wcnt_d = wcnt_q + 1'b1;
                        if (GAP_CYCLES != 0) begin
                            state_d = GAP;
                            gcnt_d  = GAP_LOAD;
                        end
                    end
                end
            end
            GAP: begin
                gcnt_d = gcnt_q - 1'b1;
                if (gcnt_q == GW'(1)) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_in_ready  = (state_q == IDLE) && !reset;
    assign data_out_valid = (state_q == SEND);
    assign busy           = (state_q != IDLE);
    assign data_out       = (MSW_FIRST != 0) ? shreg_q[PW-1 -: WORD_SIZE]
                                             : shreg_q[WORD_SIZE-1:0];

endmodule

// File: tb/tb_msg_disasm.sv
// Bench for msg_disasm: three configurations (MSW-first, LSW-first, 3-cycle gap)
// checked by fixed vectors, directed corner sequences and a random-traffic model.
module tb_msg_disasm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din   [3];
    logic        dinv  [3];
    logic        dinr  [3];
    logic [7:0]  dout  [3];
    logic        doutv [3];
    logic        doutr [3];
    logic        busy  [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int msw_of [3];
    int gap_of [3];

    // reference-model state
    logic [7:0] exp_q   [3][$];
    logic [7:0] obs     [3][$];
    int         obs_cyc [3][$];
    bit         acc_prev [3];
    bit         stall_prev [3];
    logic [7:0] word_prev [3];
    bit         in_gap [3];
    int         gap_cnt [3];
    bit         idle_exp [3];
    bit         zero_exp [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .MSW_FIRST(1), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst), .data_in(din[0]), .data_in_valid(dinv[0]),
        .data_in_ready(dinr[0]), .data_out(dout[0]), .data_out_valid(doutv[0]),
        .data_out_ready(doutr[0]), .busy(busy[0]));

    msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .MSW_FIRST(0), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst), .data_in(din[1]), .data_in_valid(dinv[1]),
        .data_in_ready(dinr[1]), .data_out(dout[1]), .data_out_valid(doutv[1]),
        .data_out_ready(doutr[1]), .busy(busy[1]));

    msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .MSW_FIRST(1), .GAP_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(rst), .data_in(din[2]), .data_in_valid(dinv[2]),
        .data_in_ready(dinr[2]), .data_out(dout[2]), .data_out_valid(doutv[2]),
        .data_out_ready(doutr[2]), .busy(busy[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Model: on accept, split the packet arithmetically into its emit-order words;
    // every word handshake must match the queue head, with the configured spacing.
    task automatic mon(input int d);
        int sh;
        if (idle_exp[d]) begin
            chk($sformatf("idle_valid%0d", d), 32'(doutv[d]), 0);
            chk($sformatf("idle_busy%0d", d), 32'(busy[d]), 0);
            chk($sformatf("idle_ready%0d", d), 32'(dinr[d]), 32'(!rst));
            if (zero_exp[d]) chk($sformatf("rst_dout%0d", d), 32'(dout[d]), 0);
            idle_exp[d] = 0;
            zero_exp[d] = 0;
        end
        if (rst) begin
            chk($sformatf("rst_ready%0d", d), 32'(dinr[d]), 0);
            exp_q[d].delete();
            acc_prev[d]   = 0;
            stall_prev[d] = 0;
            in_gap[d]     = 0;
            idle_exp[d]   = 1;
            zero_exp[d]   = 1;
            return;
        end
        if (dinr[d] !== !busy[d]) chk($sformatf("ready_vs_busy%0d", d), 32'(dinr[d]), 32'(!busy[d]));
        if (acc_prev[d]) chk($sformatf("latency%0d", d), 32'(doutv[d]), 1);
        if (stall_prev[d]) begin
            chk($sformatf("hold_valid%0d", d), 32'(doutv[d]), 1);
            chk($sformatf("hold_word%0d", d), 32'(dout[d]), 32'(word_prev[d]));
        end
        if (in_gap[d]) begin
            if (doutv[d]) begin
                chk($sformatf("gap_len%0d", d), gap_cnt[d], gap_of[d]);
                in_gap[d] = 0;
            end else begin
                gap_cnt[d]++;
                if (gap_cnt[d] > 20) begin
                    chk($sformatf("gap_timeout%0d", d), gap_cnt[d], gap_of[d]);
                    in_gap[d] = 0;
                end
            end
        end
        if (doutv[d] && doutr[d]) begin
            obs[d].push_back(dout[d]);
            obs_cyc[d].push_back(cyc);
            if (exp_q[d].size() == 0) begin
                chk($sformatf("spurious_word%0d", d), 32'(dout[d]), 32'hFFFF_FFFF);
            end else begin
                chk($sformatf("word%0d", d), 32'(dout[d]), 32'(exp_q[d].pop_front()));
                if (exp_q[d].size() == 0) idle_exp[d] = 1;
                else begin
                    in_gap[d]  = 1;
                    gap_cnt[d] = 0;
                end
            end
        end
        stall_prev[d] = doutv[d] && !doutr[d];
        word_prev[d]  = dout[d];
        acc_prev[d]   = dinv[d] && dinr[d];
        if (acc_prev[d]) begin
            for (int i = 0; i < 4; i++) begin
                sh = (msw_of[d] != 0) ? 3 - i : i;
                exp_q[d].push_back(8'(din[d] >> (8 * sh)));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) mon(d);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [31:0] p);
        int t = 0;
        while (!dinr[d] && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) chk("send_timeout", 32'(t), 0);
        din[d]  = p;
        dinv[d] = 1'b1;
        tick();
        dinv[d] = 1'b0;
        din[d]  = $urandom;
    endtask

    task automatic wait_obs(input int d, input int n);
        int t = 0;
        while (obs[d].size() < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) chk("obs_timeout", 32'(obs[d].size()), 32'(n));
        #1;
    endtask

    task automatic clear_obs(input int d);
        obs[d].delete();
        obs_cyc[d].delete();
    endtask

    typedef struct {
        int          d;
        logic [31:0] pkt;
        logic [31:0] words;  // emit order, first word in bits [31:24]
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] w;
        msw_of = '{1, 0, 1};
        gap_of = '{0, 0, 3};
        for (int d = 0; d < 3; d++) begin
            din[d] = '0; dinv[d] = 0; doutr[d] = 0;
        end
        tbl[0] = '{0, 32'h0001_0203, 32'h0001_0203};
        tbl[1] = '{1, 32'hFFFE_FDFC, 32'hFCFD_FEFF};
        tbl[2] = '{2, 32'h1122_3344, 32'h1122_3344};
        tbl[3] = '{0, 32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[4] = '{1, 32'h1234_5678, 32'h7856_3412};

        // reset held for 3 cycles
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("post_rst_ready", 32'(dinr[d]), 1);
            chk("post_rst_valid", 32'(doutv[d]), 0);
            chk("post_rst_busy", 32'(busy[d]), 0);
        end

        // fixed vectors with an always-ready sink
        foreach (tbl[k]) begin
            doutr[tbl[k].d] = 1'b1;
            clear_obs(tbl[k].d);
            send(tbl[k].d, tbl[k].pkt);
            wait_obs(tbl[k].d, 4);
            w = tbl[k].words;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("tbl%0d_w%0d", k, i), 32'(obs[tbl[k].d][i]), 32'(w[31-8*i -: 8]));
                chk($sformatf("tbl%0d_spacing%0d", k, i), obs_cyc[tbl[k].d][i] - obs_cyc[tbl[k].d][0],
                    i * (gap_of[tbl[k].d] + 1));
            end
            tick();
            chk($sformatf("tbl%0d_ready_after", k), 32'(dinr[tbl[k].d]), 1);
            repeat (2) tick();
        end

        // backpressure on the 2nd word, with a stray packet offered while busy
        doutr[0] = 1'b1;
        clear_obs(0);
        send(0, 32'hA1B2_C3D4);
        tick();
        doutr[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin din[0] = 32'h5566_7788; dinv[0] = 1'b1; end
            if (i == 2) dinv[0] = 1'b0;
            tick();
            chk("bp_valid", 32'(doutv[0]), 1);
            chk("bp_word", 32'(dout[0]), 32'hB2);
        end
        doutr[0] = 1'b1;
        wait_obs(0, 4);
        repeat (6) tick();
        chk("bp_count", 32'(obs[0].size()), 4);
        chk("bp_w0", 32'(obs[0][0]), 32'hA1);
        chk("bp_w1", 32'(obs[0][1]), 32'hB2);
        chk("bp_w2", 32'(obs[0][2]), 32'hC3);
        chk("bp_w3", 32'(obs[0][3]), 32'hD4);

        // reset after the 2nd word discards the rest of the packet
        clear_obs(0);
        send(0, 32'hDEAD_BEEF);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(doutv[0]), 0);
        chk("mid_rst_busy", 32'(busy[0]), 0);
        chk("mid_rst_dout", 32'(dout[0]), 0);
        chk("mid_rst_count", 32'(obs[0].size()), 2);
        chk("mid_rst_w0", 32'(obs[0][0]), 32'hDE);
        chk("mid_rst_w1", 32'(obs[0][1]), 32'hAD);
        tick();
        clear_obs(0);
        send(0, 32'h0102_0304);
        wait_obs(0, 4);
        repeat (4) tick();
        chk("post_rst_count", 32'(obs[0].size()), 4);
        for (int i = 0; i < 4; i++) chk("post_rst_word", 32'(obs[0][i]), 32'(i + 1));

        // random traffic on all three configurations
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 3; d++) begin
                doutr[d] = ($urandom_range(0, 9) < 7);
                dinv[d]  = ($urandom_range(0, 3) == 0);
                din[d]   = $urandom;
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            dinv[d]  = 1'b0;
            doutr[d] = 1'b1;
        end
        begin
            int t = 0;
            while ((busy[0] || busy[1] || busy[2]) && t < 200) begin
                tick();
                t++;
            end
            chk("drain_timeout", 32'(t < 200), 1);
        end
        tick();
        for (int d = 0; d < 3; d++) chk("drain_queue", 32'(exp_q[d].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/msg_disasm.md
Name: msg_disasm

Overview:
Packet-to-word serialiser, the downstream companion of msg_asm. It accepts one WORD_SIZE*WORDS_PER_PACKET packet over a valid/ready handshake and emits it as WORDS_PER_PACKET words over a second valid/ready handshake. An optional inter-word gap is provided for pacing slow sinks such as the UART TX in the test harness.

Parameters:
WORD_SIZE, 8, width of each output word in bits
WORDS_PER_PACKET, 4, number of words per packet (>=2)
MSW_FIRST, 1, 1 = emit the most significant word first; 0 = emit the least significant word first
GAP_CYCLES, 0, minimum idle cycles between a word handshake and assertion of the next word's valid (0 = back-to-back)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WORD_SIZE*WORDS_PER_PACKET  packet to serialise
data_in_valid  input  1  packet present
data_in_ready  output  1  block can accept a packet
data_out  output  WORD_SIZE  current word
data_out_valid  output  1  data_out holds a valid word
data_out_ready  input  1  sink accepts data_out this cycle
busy  output  1  high from packet accept until the last word handshake completes

Behaviour:
- Reset (reset=1 at posedge):
  - State goes to IDLE.
  - data_in_ready=1 from the first cycle after reset deasserts; it is 0 while reset is held.
  - data_out_valid=0, busy=0, data_out=0.
  - Word counter and gap counter are cleared.
  - Reset mid-packet discards the remaining words; no partial output follows.
- States: IDLE, SEND, GAP.
- IDLE:
  - data_in_ready=1, data_out_valid=0.
  - Packet accept = data_in_valid & data_in_ready at a posedge. On accept, latch data_in into the shift register, clear the word counter, go to SEND.
  - data_in is ignored while data_in_ready=0.
- SEND:
  - data_out_valid=1; data_out shows the current word (MSW_FIRST=1: bits [W*N-1 -: W] of the shift register; MSW_FIRST=0: bits [W-1:0]).
  - Latency: first word valid in the cycle after packet accept.
  - Word handshake = data_out_valid & data_out_ready.
  - Without a handshake: data_out and data_out_valid hold stable, with no change for any number of cycles.
  - Handshake on the last word (counter == WORDS_PER_PACKET-1): go to IDLE; data_in_ready=1 in the next cycle.
  - Handshake on any other word: shift the register by WORD_SIZE toward the emit end, increment the counter, then:
    - GAP_CYCLES=0: stay in SEND with the next word valid in the next cycle.
    - Otherwise: go to GAP with the gap counter loaded with GAP_CYCLES.
- GAP:
  - data_out_valid=0, data_in_ready=0.
  - The gap counter decrements each cycle; at 1, go to SEND.
  - Result: exactly GAP_CYCLES cycles with valid low between words.
- busy is 1 in SEND and GAP, 0 in IDLE.
- Throughput:
  - GAP_CYCLES=0 with a permanently ready sink: one word per cycle, and a new packet is accepted one cycle after the last word.
  - Packet period = WORDS_PER_PACKET+1 cycles.
- No simultaneous accept with the last-word handshake; this is decided for simplicity.
- Counter widths: $clog2(WORDS_PER_PACKET) bits for the word counter, $clog2(GAP_CYCLES+1) bits for the gap counter (minimum 1 bit).
- data_out is a registered output.

Test Plan:
1. Reset held 3 cycles then released, no input → data_in_ready=1, data_out_valid=0, busy=0; with reset asserted, data_in_ready=0.
2. Defaults (W=8, N=4, MSW_FIRST=1, GAP=0), data_out_ready=1, send packet 0x00010203 → words 00, 01, 02, 03 on 4 consecutive cycles starting 1 cycle after accept; then data_in_ready=1.
3. MSW_FIRST=0, packet 0xFFFEFDFC → words FC, FD, FE, FF in that order.
4. Backpressure: packet 0xA1B2C3D4, data_out_ready low for 5 cycles on the 2nd word → B2 held stable with valid=1 for 5 cycles, no word lost or duplicated; data_in_valid pulsed during busy is ignored.
5. GAP_CYCLES=3, packet 0x11223344 → valid low for exactly 3 cycles between each word handshake; last word followed by IDLE with no gap.
6. Reset asserted after the 2nd word of 0xDEADBEEF → valid=0, busy=0 next cycle; new packet 0x01020304 then emits 01, 02, 03, 04 with no residue of the old packet.
